// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage feeding mips_cpu: credit-limited word reads,
// in-order response capture into a prefetch queue, redirect flush.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH = FIFO_DEPTH[CW:0];

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] out_next;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [31:0]   q_data [FIFO_DEPTH];
  logic [31:0]   q_pc   [FIFO_DEPTH];

  logic          req_fire;
  logic          resp_fire;
  logic          push;
  logic          pop;
  logic          not_empty;
  logic [CW:0]   credit_used;
  logic [31:0]   redir_pc;

  assign redir_pc    = {redirect_pc[31:2], 2'b00};
  assign credit_used = {1'b0, count} + {1'b0, outstanding};
  assign not_empty   = (count != '0);

  // Queued plus in-flight words never exceed the queue size, so a
  // returning response always has a free slot.
  assign imem_req_valid = reset_n & ~redirect_valid
                        & (credit_used < DEPTH);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign resp_fire = imem_resp_valid & (outstanding != '0);
  assign push      = resp_fire & (drop == '0) & ~redirect_valid;
  assign out_next  = outstanding - CW'(resp_fire);

  assign instr_valid = not_empty & ~redirect_valid;
  assign pop         = instr_valid & instr_ready;
  assign instruction = not_empty ? q_data[rptr] : '0;
  assign instr_pc    = not_empty ? q_pc[rptr] : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      wptr        <= '0;
      rptr        <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight belongs to the old path.
      fetch_pc    <= redir_pc;
      resp_pc     <= redir_pc;
      count       <= '0;
      wptr        <= '0;
      rptr        <= '0;
      outstanding <= out_next;
      drop        <= out_next;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (push) begin
        resp_pc <= resp_pc + 32'd4;
        wptr    <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      count       <= count + CW'(push) - CW'(pop);
      outstanding <= out_next + CW'(req_fire);
      if (resp_fire && (drop != '0)) begin
        drop <= drop - CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      q_data[wptr] <= imem_resp_data;
      q_pc[wptr]   <= resp_pc;
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: directed scenarios, memory model,
// expected-instruction queue checked by an independent monitor.
module tb_mips_fetch_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  mips_fetch_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } preq_t;

  exp_t        sb[$];
  preq_t       pend[$];
  logic [31:0] reqlog[$];
  int          checks = 0;
  int          failures = 0;
  int          lat = 1;
  int          t = 0;
  int          idx;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h2008_0006;
    if (a == 32'h0040_0004) return 32'h2009_000B;
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] pc,
                             input logic [31:0] ins);
    exp_t e;
    e.pc  = pc;
    e.ins = ins;
    sb.push_back(e);
  endtask

  // Memory: inputs are settled at the falling edge; a handshake seen
  // here completes on the next rising edge, numbered t.
  always @(negedge clock) begin
    preq_t p;
    #1;
    t++;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (pend.size() != 0 && pend[0].due <= t) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = memword(pend[0].addr);
      void'(pend.pop_front());
    end
    if (reset_n && imem_req_valid && imem_req_ready) begin
      p.addr = imem_req_addr;
      p.due  = t + lat;
      if (pend.size() != 0 && p.due <= pend[$].due)
        p.due = pend[$].due + 1;
      pend.push_back(p);
      reqlog.push_back(imem_req_addr);
    end
  end

  // Monitor: every pop the core will take on the next edge is compared.
  always @(negedge clock) begin
    exp_t e;
    #2;
    if (reset_n && instr_valid && instr_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pop got pc=%h ins=%h required none",
                 instr_pc, instruction);
      end else begin
        e = sb.pop_front();
        if (instr_pc !== e.pc || instruction !== e.ins) begin
          failures++;
          $display("FAIL pop got pc=%h ins=%h required pc=%h ins=%h",
                   instr_pc, instruction, e.pc, e.ins);
        end
      end
    end
  end

  task automatic drain(input string nm);
    int n;
    @(negedge clock);
    instr_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    instr_ready = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain left=%0d required=0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    imem_req_ready = 1'b1;
    #3;
    pend.delete();
    reqlog.delete();
    imem_resp_valid = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // reset values
    @(negedge clock);
    #3;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instruction", instruction, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);

    // first fetches, 1-cycle memory
    @(negedge clock);
    lat = 1;
    pend.delete();
    reqlog.delete();
    expect_word(32'h0040_0000, 32'h2008_0006);
    expect_word(32'h0040_0004, 32'h2009_000B);
    reset_n     = 1'b1;
    instr_ready = 1'b1;
    @(negedge clock);
    #3 chk("t1_valid_c1", 32'(instr_valid), 32'd0);
    @(negedge clock);
    #3 chk("t1_valid_c2", 32'(instr_valid), 32'd1);
    drain("t1");

    // core stalled: credit limit
    lat = 1;
    do_reset();
    reset_n = 1'b1;
    repeat (7) @(negedge clock);
    #3;
    chk("t2_req_count", 32'(reqlog.size()), 32'd4);
    chk("t2_last_addr", reqlog[$], 32'h0040_000C);
    chk("t2_req_valid", 32'(imem_req_valid), 32'd0);
    expect_word(32'h0040_0000, 32'h2008_0006);
    expect_word(32'h0040_0004, 32'h2009_000B);
    expect_word(32'h0040_0008, 32'hA5E5_0008);
    expect_word(32'h0040_000C, 32'hA5E5_000C);
    drain("t2");
    repeat (3) @(negedge clock);
    chk("t2_next_addr",
        (reqlog.size() > 4) ? reqlog[4] : 32'hDEAD_DEAD, 32'h0040_0010);

    // redirect with three reads in flight, 3-cycle memory
    lat = 3;
    do_reset();
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0100;
    #3;
    chk("t3_redir_valid", 32'(instr_valid), 32'd0);
    chk("t3_redir_req", 32'(imem_req_valid), 32'd0);
    @(negedge clock);
    redirect_valid = 1'b0;
    expect_word(32'h0040_0100, 32'hA5E5_0100);
    expect_word(32'h0040_0104, 32'hA5E5_0104);
    drain("t3");

    // unaligned redirect coincident with response and ready core
    lat = 1;
    do_reset();
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0103;
    instr_ready    = 1'b1;
    #3 chk("t4_redir_valid", 32'(instr_valid), 32'd0);
    @(negedge clock);
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    #3;
    chk("t4_flushed", 32'(instr_valid), 32'd0);
    chk("t4_next_addr", imem_req_addr, 32'h0040_0100);
    expect_word(32'h0040_0100, 32'hA5E5_0100);
    expect_word(32'h0040_0104, 32'hA5E5_0104);
    drain("t4");

    // memory back-pressure, then address wrap
    lat = 1;
    do_reset();
    imem_req_ready = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      #3;
      chk("t5_hold_addr", imem_req_addr, 32'h0040_0000);
      chk("t5_hold_valid", 32'(imem_req_valid), 32'd1);
    end
    chk("t5_no_handshake", 32'(pend.size() + reqlog.size()), 32'd0);
    @(negedge clock);
    imem_req_ready = 1'b1;
    expect_word(32'h0040_0000, 32'h2008_0006);
    expect_word(32'h0040_0004, 32'h2009_000B);
    drain("t5");
    @(negedge clock);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    idx = reqlog.size();
    @(negedge clock);
    redirect_valid = 1'b0;
    expect_word(32'hFFFF_FFFC, 32'h5A5A_FFFC);
    expect_word(32'h0000_0000, 32'hA5A5_0000);
    drain("t5_wrap");
    chk("t5_wrap_a0",
        (reqlog.size() > idx) ? reqlog[idx] : 32'hDEAD_DEAD,
        32'hFFFF_FFFC);
    chk("t5_wrap_a1",
        (reqlog.size() > idx + 1) ? reqlog[idx+1] : 32'hDEAD_DEAD,
        32'h0000_0000);

    // asynchronous reset mid-stream
    lat = 3;
    do_reset();
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    #3;
    chk("t6_pre_valid", 32'(instr_valid), 32'd1);
    chk("t6_pre_instr", instruction, 32'h2008_0006);
    reset_n = 1'b0;
    pend.delete();
    reqlog.delete();
    imem_resp_valid = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(instr_valid), 32'd0);
    chk("t6_rst_instr", instruction, 32'd0);
    chk("t6_rst_pc", instr_pc, 32'd0);
    chk("t6_rst_req", 32'(imem_req_valid), 32'd0);
    @(negedge clock);
    lat = 1;
    @(negedge clock);
    reset_n = 1'b1;
    expect_word(32'h0040_0000, 32'h2008_0006);
    expect_word(32'h0040_0004, 32'h2009_000B);
    drain("t6");
    chk("t6_first_addr",
        (reqlog.size() > 0) ? reqlog[0] : 32'hDEAD_DEAD, 32'h0040_0000);

    repeat (3) @(negedge clock);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
